// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/stall sequencer for a 5-stage MIPS pipeline.
// It drives the enables and flushes of the PC, IF/ID and ID/EX registers.
// The outputs are combinational from the state, md_cnt and the inputs, so a
// hazard seen in a cycle is acted on in that same cycle.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous reset, active-low
//   id_rs, id_rt    source register addresses of the instruction in ID
//   id_uses_rt      the ID instruction reads rt as a source
//   ex_memread      the EX instruction is a load
//   ex_rt           destination register of the load in EX
//   ex_md_start     a MULT/DIV entered EX this cycle
//   ex_branch_taken a branch in EX resolved as taken
//   pc_en           PC load enable
//   ifid_en         IF/ID register enable
//   idex_en         ID/EX register enable
//   ifid_flush      clear IF/ID to a NOP on the next edge
//   idex_flush      clear ID/EX to a bubble on the next edge
//   md_busy         a MULT/DIV is in progress
//   md_done         one-cycle pulse on the last MULT/DIV cycle
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 32,  // EX cycles a MULT/DIV occupies, 2..63
  parameter int unsigned CW     = 6    // counter width, 2**CW > MD_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_md_start,
  input  logic       ex_branch_taken,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       md_busy,
  output logic       md_done
);

  localparam int unsigned REG_AW = 5;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_MDWAIT = 1'b1;

  // Value loaded on MULT/DIV entry; the entry cycle counts as the first
  // frozen cycle, so the wait state covers the remaining MD_LAT-1 cycles.
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_LAT - 1);
  localparam logic [CW-1:0] MD_ONE  = CW'(1);

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [CW-1:0] md_cnt;
  logic [CW-1:0] md_cnt_nxt;

  logic          rs_match_c;
  logic          rt_match_c;
  logic          load_use_c;

  // Load-use detection; register $zero never creates a dependency.
  always_comb begin
    rs_match_c = (ex_rt == id_rs);
    rt_match_c = id_uses_rt && (ex_rt == id_rt);
    load_use_c = ex_memread && (ex_rt != REG_AW'(0)) && (rs_match_c || rt_match_c);
  end

  // State and MULT/DIV counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_busy    = 1'b0;
    md_done    = 1'b0;

    case (state)
      ST_RUN: begin
        md_cnt_nxt = '0;
        if (ex_branch_taken) begin
          // Taken branch wins: the younger instructions are discarded, so
          // any hazard or MULT/DIV start they signal is irrelevant.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (ex_md_start) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          state_nxt  = ST_MDWAIT;
          md_cnt_nxt = MD_LOAD;
        end else if (load_use_c) begin
          // Hold PC and IF/ID, insert one bubble into EX.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end

      ST_MDWAIT: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        md_busy = 1'b1;
        if (md_cnt == MD_ONE) begin
          md_done    = 1'b1;
          state_nxt  = ST_RUN;
          md_cnt_nxt = '0;
        end else if (md_cnt == '0) begin
          // Unreachable in normal operation; leave without underflowing.
          state_nxt  = ST_RUN;
        end else begin
          md_cnt_nxt = md_cnt - MD_ONE;
        end
      end

      default: begin
        state_nxt  = ST_RUN;
        md_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MD_LAT=4.
// Inputs change 1 time unit after the rising edge; the combinational outputs
// are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       ex_md_start;
  logic       ex_branch_taken;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       md_busy;
  logic       md_done;

  int checks;
  int failures;

  // Output vector order: pc_en, ifid_en, idex_en, ifid_flush, idex_flush,
  // md_busy, md_done.
  localparam logic [6:0] O_RUN   = 7'b1110000;
  localparam logic [6:0] O_STALL = 7'b0010100;
  localparam logic [6:0] O_FLUSH = 7'b1111100;
  localparam logic [6:0] O_MDST  = 7'b0000000;
  localparam logic [6:0] O_MDW   = 7'b0000010;
  localparam logic [6:0] O_MDD   = 7'b0000011;

  pipe_hazard_ctrl #(.MD_LAT(4), .CW(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_md_start     (ex_md_start),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .md_busy         (md_busy),
    .md_done         (md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd3;
    ex_md_start = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    @(negedge clk);
    obs = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, md_busy, md_done};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // 1. Reset with random inputs, then release.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id_rs = 5'($urandom); id_rt = 5'($urandom); id_uses_rt = 1'($urandom);
      ex_memread = 1'($urandom); ex_rt = 5'($urandom);
      ex_md_start = 1'($urandom); ex_branch_taken = 1'($urandom);
      next_cycle();
    end
    idle();
    check("reset_held", O_RUN);
    next_cycle();
    rst = 1'b1;
    check("reset_release", O_RUN);
    next_cycle();
    check("run_idle", O_RUN);

    // 2. Load-use on rs, then the bubble cycle.
    next_cycle();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    check("loaduse_rs", O_STALL);
    next_cycle();
    ex_memread = 1'b0;
    check("after_stall", O_RUN);

    // Load-use on rt when rt is a source.
    next_cycle();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
    check("loaduse_rt", O_STALL);

    // 3. No-hazard cases.
    next_cycle();
    idle();
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    check("zero_reg", O_RUN);
    next_cycle();
    idle();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
    check("rt_unused", O_RUN);
    next_cycle();
    idle();
    ex_memread = 1'b0; ex_rt = 5'd8; id_rs = 5'd8;
    check("not_load", O_RUN);

    // 4. MULT/DIV: 4 frozen cycles, busy on 2-4, done on 4; inputs ignored.
    next_cycle();
    idle();
    ex_md_start = 1'b1;
    check("md_c1", O_MDST);
    next_cycle();
    ex_md_start = 1'b0; ex_branch_taken = 1'b1;
    check("md_c2_ignore_branch", O_MDW);
    next_cycle();
    ex_branch_taken = 1'b0; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    check("md_c3_ignore_loaduse", O_MDW);
    next_cycle();
    idle();
    ex_md_start = 1'b1;
    check("md_c4_done", O_MDD);
    next_cycle();
    idle();
    check("md_after", O_RUN);

    // 5. Branch together with load-use and MULT/DIV start.
    next_cycle();
    ex_branch_taken = 1'b1; ex_md_start = 1'b1;
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    check("simul_flush", O_FLUSH);
    next_cycle();
    idle();
    check("simul_no_mdwait", O_RUN);

    // 6. Reset on the 2nd MDWAIT cycle.
    next_cycle();
    ex_md_start = 1'b1;
    check("rmd_c1", O_MDST);
    next_cycle();
    ex_md_start = 1'b0;
    check("rmd_c2", O_MDW);
    next_cycle();
    rst = 1'b0;
    check("rmd_abort", O_RUN);
    next_cycle();
    rst = 1'b1;
    check("rmd_release", O_RUN);
    next_cycle();
    check("rmd_no_done", O_RUN);

    // A fresh MULT/DIV after the abort takes the full latency again.
    next_cycle();
    ex_md_start = 1'b1;
    check("md2_c1", O_MDST);
    next_cycle();
    ex_md_start = 1'b0;
    check("md2_c2", O_MDW);
    next_cycle();
    check("md2_c3", O_MDW);
    next_cycle();
    check("md2_c4_done", O_MDD);
    next_cycle();
    check("md2_after", O_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
